// File: rtl/intersection_pkg.sv
// Shared types for the intersection controller: the phase enum and the
// fixed phase-order constants used by the FSM.
package intersection_pkg;

    typedef enum logic [2:0] {
        NS_GRN    = 3'd0,
        NS_YEL    = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GRN    = 3'd3,
        EW_YEL    = 3'd4,
        RED_TO_NS = 3'd5
    } phase_e;

    localparam phase_e FIRST_PHASE = NS_GRN;
    localparam phase_e LAST_PHASE  = RED_TO_NS;

    function automatic phase_e next_phase(input phase_e p);
        if (p == LAST_PHASE) begin
            return FIRST_PHASE;
        end
        return phase_e'(p + 3'd1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every DIV clocks.
module ms_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// Two-road traffic controller with NS as the rest road. Pedestrian walk
// signals are built only when PED_SIGNALS_EN is defined.
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int GREEN_MS       = 10000,
    parameter int YELLOW_MS      = 3000,
    parameter int ALL_RED_MS     = 1000,
    parameter int PED_CAUTION_MS = 4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ns_sensor,
    input  logic        ew_sensor,
    input  logic        pd_button_ns,
    input  logic        pd_button_ew,
    output logic        NS_RED,
    output logic        NS_YELLOW,
    output logic        NS_GREEN,
    output logic        EW_RED,
    output logic        EW_YELLOW,
    output logic        EW_GREEN,
    output logic        pd_FREE_NS,
    output logic        pd_CAUTION_NS,
    output logic        pd_FREE_EW,
    output logic        pd_CAUTION_EW,
    output logic [31:0] time_left_ms_ns,
    output logic [31:0] time_left_ms_ew
);

    localparam int TICK_DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam logic [31:0] GREEN_T   = 32'(GREEN_MS);
    localparam logic [31:0] YELLOW_T  = 32'(YELLOW_MS);
    localparam logic [31:0] ALL_RED_T = 32'(ALL_RED_MS);
    localparam logic [31:0] CAUTION_T = 32'(PED_CAUTION_MS);

    logic tick;
    logic btn_ns_in, btn_ew_in;

    phase_e      state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] tl_ns_q, tl_ns_d, tl_ew_q, tl_ew_d;
    logic        ns_sens_q, ew_sens_q, btn_ns_q, btn_ew_q;
    logic        ns_req_q, ns_req_d, ew_req_q, ew_req_d;
    logic        ped_ns_req_q, ped_ns_req_d, ped_ew_req_q, ped_ew_req_d;
    logic        walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic        clr_ns, clr_ew, clr_ped_ns, clr_ped_ew;

    ms_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef PED_SIGNALS_EN
    assign btn_ns_in = pd_button_ns;
    assign btn_ew_in = pd_button_ew;
`else
    // Buttons are ignored; with no ped requests the walk logic folds to 0.
    logic unused_buttons;
    assign unused_buttons = pd_button_ns ^ pd_button_ew;
    assign btn_ns_in = 1'b0;
    assign btn_ew_in = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        walk_ns_d  = walk_ns_q;
        walk_ew_d  = walk_ew_q;
        clr_ns     = 1'b0;
        clr_ew     = 1'b0;
        clr_ped_ns = 1'b0;
        clr_ped_ew = 1'b0;
        if (tick && counter_q != '0) begin
            counter_d = counter_q - 32'd1;
        end
        // Phase decisions are taken once the counter has drained to zero.
        if (counter_q == '0) begin
            case (state_q)
                NS_GRN: begin
                    if (ew_req_q || ped_ew_req_q) begin
                        state_d   = next_phase(state_q);
                        counter_d = YELLOW_T;
                        walk_ns_d = 1'b0;
                    end else if (ped_ns_req_q) begin
                        counter_d  = GREEN_T;
                        walk_ns_d  = 1'b1;
                        clr_ped_ns = 1'b1;
                    end
                end
                NS_YEL, EW_YEL: begin
                    state_d   = next_phase(state_q);
                    counter_d = ALL_RED_T;
                end
                RED_TO_EW: begin
                    state_d    = next_phase(state_q);
                    counter_d  = GREEN_T;
                    walk_ew_d  = ped_ew_req_q;
                    clr_ew     = 1'b1;
                    clr_ped_ew = 1'b1;
                end
                EW_GRN: begin
                    state_d   = next_phase(state_q);
                    counter_d = YELLOW_T;
                    walk_ew_d = 1'b0;
                end
                RED_TO_NS: begin
                    state_d    = next_phase(state_q);
                    counter_d  = GREEN_T;
                    walk_ns_d  = ped_ns_req_q;
                    clr_ns     = 1'b1;
                    clr_ped_ns = 1'b1;
                end
                default: begin
                    state_d   = FIRST_PHASE;
                    counter_d = GREEN_T;
                end
            endcase
        end
        ns_req_d     = (ns_req_q & ~clr_ns) | (ns_sensor & ~ns_sens_q);
        ew_req_d     = (ew_req_q & ~clr_ew) | (ew_sensor & ~ew_sens_q);
        ped_ns_req_d = (ped_ns_req_q & ~clr_ped_ns) | (btn_ns_in & ~btn_ns_q);
        ped_ew_req_d = (ped_ew_req_q & ~clr_ped_ew) | (btn_ew_in & ~btn_ew_q);
        tl_ns_d = (state_d == NS_GRN || state_d == NS_YEL) ? counter_d : '0;
        tl_ew_d = (state_d == EW_GRN || state_d == EW_YEL) ? counter_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FIRST_PHASE;
            counter_q    <= GREEN_T;
            tl_ns_q      <= GREEN_T;
            tl_ew_q      <= '0;
            ns_sens_q    <= 1'b0;
            ew_sens_q    <= 1'b0;
            btn_ns_q     <= 1'b0;
            btn_ew_q     <= 1'b0;
            ns_req_q     <= 1'b0;
            ew_req_q     <= 1'b0;
            ped_ns_req_q <= 1'b0;
            ped_ew_req_q <= 1'b0;
            walk_ns_q    <= 1'b0;
            walk_ew_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            tl_ns_q      <= tl_ns_d;
            tl_ew_q      <= tl_ew_d;
            ns_sens_q    <= ns_sensor;
            ew_sens_q    <= ew_sensor;
            btn_ns_q     <= btn_ns_in;
            btn_ew_q     <= btn_ew_in;
            ns_req_q     <= ns_req_d;
            ew_req_q     <= ew_req_d;
            ped_ns_req_q <= ped_ns_req_d;
            ped_ew_req_q <= ped_ew_req_d;
            walk_ns_q    <= walk_ns_d;
            walk_ew_q    <= walk_ew_d;
        end
    end

    always_comb begin
        NS_GREEN        = (state_q == NS_GRN);
        NS_YELLOW       = (state_q == NS_YEL);
        NS_RED          = !(NS_GREEN || NS_YELLOW);
        EW_GREEN        = (state_q == EW_GRN);
        EW_YELLOW       = (state_q == EW_YEL);
        EW_RED          = !(EW_GREEN || EW_YELLOW);
        pd_FREE_NS      = NS_GREEN && walk_ns_q && (counter_q > CAUTION_T);
        pd_CAUTION_NS   = NS_GREEN && walk_ns_q && (counter_q != '0) && (counter_q <= CAUTION_T);
        pd_FREE_EW      = EW_GREEN && walk_ew_q && (counter_q > CAUTION_T);
        pd_CAUTION_EW   = EW_GREEN && walk_ew_q && (counter_q != '0) && (counter_q <= CAUTION_T);
        time_left_ms_ns = tl_ns_q;
        time_left_ms_ew = tl_ew_q;
    end

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller at one ms tick per clock,
// compared cycle by cycle against a phase-table reference model.
module tb_intersection_controller;

    localparam int GREEN   = 10;
    localparam int YELLOW  = 3;
    localparam int ALL_RED = 2;
    localparam int CAUTION = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ns_sensor = 1'b0, ew_sensor = 1'b0, pd_button_ns = 1'b0, pd_button_ew = 1'b0;
    logic NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN;
    logic pd_FREE_NS, pd_CAUTION_NS, pd_FREE_EW, pd_CAUTION_EW;
    logic [31:0] time_left_ms_ns, time_left_ms_ew;

    int errors = 0;
    int checks = 0;

    intersection_controller #(
        .CLK_FREQ_HZ    (1000),
        .GREEN_MS       (GREEN),
        .YELLOW_MS      (YELLOW),
        .ALL_RED_MS     (ALL_RED),
        .PED_CAUTION_MS (CAUTION)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ns_sensor       (ns_sensor),
        .ew_sensor       (ew_sensor),
        .pd_button_ns    (pd_button_ns),
        .pd_button_ew    (pd_button_ew),
        .NS_RED          (NS_RED),
        .NS_YELLOW       (NS_YELLOW),
        .NS_GREEN        (NS_GREEN),
        .EW_RED          (EW_RED),
        .EW_YELLOW       (EW_YELLOW),
        .EW_GREEN        (EW_GREEN),
        .pd_FREE_NS      (pd_FREE_NS),
        .pd_CAUTION_NS   (pd_CAUTION_NS),
        .pd_FREE_EW      (pd_FREE_EW),
        .pd_CAUTION_EW   (pd_CAUTION_EW),
        .time_left_ms_ns (time_left_ms_ns),
        .time_left_ms_ew (time_left_ms_ew)
    );

    always #5 clk = ~clk;

    // Reference model: phase index 0..5 walks a table of durations and lamp
    // patterns ({red,yellow,green}); index 0 is NS green, 3 is EW green.
    int m_phase, m_rem;
    bit m_ew_req, m_ped_ns, m_ped_ew, m_walk_ns, m_walk_ew;
    bit p_ns, p_ew, p_pns, p_pew;
    int dur [6] = '{GREEN, YELLOW, ALL_RED, GREEN, YELLOW, ALL_RED};
    logic [2:0] ns_pat [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_pat [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic modelStep();
        bit r_ew, r_pns, r_pew;
        if (!rst) begin
            m_phase = 0; m_rem = GREEN;
            m_ew_req = 0; m_ped_ns = 0; m_ped_ew = 0; m_walk_ns = 0; m_walk_ew = 0;
            p_ns = 0; p_ew = 0; p_pns = 0; p_pew = 0;
        end else begin
            r_ew = ew_sensor && !p_ew;
`ifdef PED_SIGNALS_EN
            r_pns = pd_button_ns && !p_pns;
            r_pew = pd_button_ew && !p_pew;
`else
            r_pns = 0;
            r_pew = 0;
`endif
            if (m_rem > 0) begin
                m_rem--;
            end else if (m_phase == 0) begin
                if (m_ew_req || m_ped_ew) begin
                    m_phase = 1; m_rem = YELLOW; m_walk_ns = 0;
                end else if (m_ped_ns) begin
                    m_rem = GREEN; m_walk_ns = 1; m_ped_ns = 0;
                end
            end else begin
                m_phase = (m_phase + 1) % 6;
                m_rem = dur[m_phase];
                if (m_phase == 3) begin m_walk_ew = m_ped_ew; m_ew_req = 0; m_ped_ew = 0; end
                if (m_phase == 4) m_walk_ew = 0;
                if (m_phase == 0) begin m_walk_ns = m_ped_ns; m_ped_ns = 0; end
            end
            m_ew_req |= r_ew;
            m_ped_ns |= r_pns;
            m_ped_ew |= r_pew;
            p_ns = ns_sensor; p_ew = ew_sensor; p_pns = pd_button_ns; p_pew = pd_button_ew;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] exp_pd;
        bit ns_walk_on, ew_walk_on;
        ns_walk_on = (m_phase == 0) && m_walk_ns;
        ew_walk_on = (m_phase == 3) && m_walk_ew;
        exp_pd = {ns_walk_on && m_rem > CAUTION, ns_walk_on && m_rem > 0 && m_rem <= CAUTION,
                  ew_walk_on && m_rem > CAUTION, ew_walk_on && m_rem > 0 && m_rem <= CAUTION};
        checkValue("lamps", 32'({NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}),
                   32'({ns_pat[m_phase], ew_pat[m_phase]}));
        checkValue("ped", 32'({pd_FREE_NS, pd_CAUTION_NS, pd_FREE_EW, pd_CAUTION_EW}), 32'(exp_pd));
        checkValue("tl_ns", time_left_ms_ns, (m_phase <= 1) ? 32'(m_rem) : 32'd0);
        checkValue("tl_ew", time_left_ms_ew, (m_phase == 3 || m_phase == 4) ? 32'(m_rem) : 32'd0);
        checkValue("one_red", 32'(NS_RED | EW_RED), 32'd1);
    endtask

    task automatic applyStimulus(input logic r, input logic ns, input logic ew,
                                 input logic pns, input logic pew);
        rst = r; ns_sensor = ns; ew_sensor = ew; pd_button_ns = pns; pd_button_ew = pew;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        runCycles(3);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(100);
        // EW vehicle while NS rests: full cycle back to NS.
        applyStimulus(1, 0, 1, 0, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(45);
        // NS vehicle on the rest road changes nothing.
        applyStimulus(1, 1, 0, 0, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(20);
        // NS pedestrian during rest: reload and walk profile.
        applyStimulus(1, 0, 0, 1, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(20);
        // EW pedestrian during rest: EW phase with walk profile.
        applyStimulus(1, 0, 0, 0, 1);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(50);
        // Reset in the middle of EW green.
        applyStimulus(1, 0, 1, 0, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(13);
        applyStimulus(0, 0, 0, 0, 0);
        runCycles(1);
        applyStimulus(1, 0, 0, 0, 0);
        runCycles(15);
        // Random traffic, presses and occasional resets.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 29) == 0));
            runCycles(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, clock frequency; the millisecond tick period is CLK_FREQ_HZ/1000 cycles.
REQ-002 SHALL have parameters GREEN_MS=10000, YELLOW_MS=3000, ALL_RED_MS=1000, PED_CAUTION_MS=4000: phase durations in ms; PED_CAUTION_MS < GREEN_MS.
REQ-003 SHALL use one clock and a synchronous active-low reset: clk input 1 (rising edge), then rst input 1 (synchronous, active-low).
REQ-004 ns_sensor, ew_sensor input 1: vehicle-present level/pulse per approach.
REQ-005 pd_button_ns, pd_button_ew input 1: pedestrian request to cross parallel to NS/EW traffic.
REQ-006 NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN output 1 each: lamp drives.
REQ-007 pd_FREE_NS, pd_CAUTION_NS, pd_FREE_EW, pd_CAUTION_EW output 1 each: walk / flashing-don't-walk.
REQ-008 time_left_ms_ns, time_left_ms_ew output 32: ms remaining in that direction's current green/yellow; 0 while that direction is red.

Function
REQ-009 The FSM SHALL have states NS_GRN, NS_YEL, RED_TO_EW, EW_GRN, EW_YEL, RED_TO_NS, cycling in that order.
REQ-010 A one-cycle ms tick SHALL fire every CLK_FREQ_HZ/1000 clocks; a phase counter loads the phase duration on entry and decrements on each tick down to 0.
REQ-011 Lamps SHALL decode from the state register: exactly one lamp per direction; NS and EW are never both non-red.
REQ-012 Rising sensor/button levels SHALL set request latches ew_req, ns_req, ped_ns_req, ped_ew_req; a set occurring in the same cycle as a clear takes precedence.
REQ-013 NS_GRN with counter 0 SHALL go to NS_YEL if ew_req or ped_ew_req is set; otherwise it rests in NS_GRN.
REQ-014 While resting in NS_GRN with ped_ns_req set, the counter SHALL reload GREEN_MS so that a fresh walk interval is served.
REQ-015 EW_GRN SHALL go to EW_YEL when its counter reaches 0 unconditionally; NS is the rest road.
REQ-016 YEL states SHALL last YELLOW_MS and RED_TO_* states ALL_RED_MS, then advance.
REQ-017 Entering EW_GRN SHALL clear ew_req; entering NS_GRN SHALL clear ns_req. A ped latch SHALL clear when its green is entered, and that green then grants the walk.
REQ-018 pd_FREE_x SHALL be asserted when x is green, the walk is granted, and counter > PED_CAUTION_MS.
REQ-019 pd_CAUTION_x SHALL be asserted when x is green, the walk is granted, and 0 < counter <= PED_CAUTION_MS.
REQ-020 Otherwise pd_FREE_x and pd_CAUTION_x SHALL both be 0, and they are never both 1.
REQ-021 time_left outputs SHALL be registered and equal the phase counter of the non-red direction, updated in the same cycle as the counter.

Reset
REQ-022 rst=0 at a clock edge SHALL force state NS_GRN, counter=GREEN_MS, and prescaler and all latches to 0.
REQ-023 During reset: NS_GREEN=1, EW_RED=1, other lamps 0, all pd_* 0, time_left_ms_ns=GREEN_MS, time_left_ms_ew=0; reset mid-phase aborts the phase immediately.

Configuration
REQ-024 With PED_SIGNALS_EN defined, pedestrian latches and pd_* outputs SHALL behave as above.
REQ-025 Without PED_SIGNALS_EN, pd_* outputs SHALL be tied 0, buttons ignored, and REQ-014 omitted.

Structure
REQ-026 Package intersection_pkg SHALL hold the state enum typedef and the phase-order constants.
REQ-027 Sub-module ms_tick_gen SHALL implement the ms prescaler; the FSM, latches and decode stay in intersection_controller.

Verification (CLK_FREQ_HZ=1000 so 1 tick/cycle; GREEN_MS=10, YELLOW_MS=3, ALL_RED_MS=2, PED_CAUTION_MS=4)
REQ-028 Reset held then released, no inputs for 100 cycles -> NS_GREEN=1, EW_RED=1 throughout; time_left_ms_ns counts 10 to 0 and holds 0.
REQ-029 ew_sensor pulse while resting -> NS_YEL for 3 cycles, all-red for 2, EW_GRN for 10 with time_left_ms_ew 10 to 0, then EW_YEL 3, all-red 2, back to NS_GRN.
REQ-030 ns_sensor pulse during NS rest -> no state change.
REQ-031 pd_button_ns during NS rest -> counter reloads to 10; pd_FREE_NS=1 while counter 10..5, pd_CAUTION_NS=1 while 4..1, both 0 at 0.
REQ-032 pd_button_ew during NS rest -> EW phase entered; pd_FREE_EW/pd_CAUTION_EW follow the REQ-031 profile during EW_GRN.
REQ-033 rst=0 asserted mid EW_GRN -> the next cycle shows the REQ-023 values; in every cycle, NS and EW are never simultaneously non-red.
